// File: rtl/instr_decode_stage.sv
// Instruction-decode pipeline stage.
// Splits a 32-bit instruction word into opcode/register fields, builds the
// extended immediate and the use_imm / reg_write / illegal control flags, and
// presents them through a single registered output slice.
//
// Handshake: a beat moves on any rising edge where valid && ready are both
// high on that side. The producer holds valid and its payload stable until
// ready is seen; ready may depend combinationally on the other side's ready
// (in_ready = !out_valid || out_ready) but never on in_valid. flush takes
// priority: it empties the slice and the beat offered in that cycle is
// dropped (so it is neither accepted nor counted as delivered).
module instr_decode_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_instr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [5:0]        opcode,
  output logic [REG_AW-1:0] rd,
  output logic [REG_AW-1:0] rs1,
  output logic [REG_AW-1:0] rs2,
  output logic [DATA_W-1:0] imme_value,
  output logic              use_imm,
  output logic              reg_write,
  output logic              illegal,
  output logic              illegal_seen,
  output logic [CNT_W-1:0]  instr_count
);

  // ISA opcode map. Values 21, 22 and 25..63 are not part of the ISA.
  typedef enum logic [5:0] {
    OP_NOP   = 6'd0,
    OP_ADD   = 6'd1,
    OP_SUB   = 6'd2,
    OP_STORE = 6'd3,
    OP_LOAD  = 6'd4,
    OP_MOVE  = 6'd5,
    OP_SGE   = 6'd6,
    OP_SLE   = 6'd7,
    OP_SGT   = 6'd8,
    OP_SLT   = 6'd9,
    OP_SEQ   = 6'd10,
    OP_SNE   = 6'd11,
    OP_AND   = 6'd12,
    OP_OR    = 6'd13,
    OP_XOR   = 6'd14,
    OP_NOT   = 6'd15,
    OP_MOVEI = 6'd16,
    OP_SLI   = 6'd17,
    OP_SRI   = 6'd18,
    OP_ADDI  = 6'd19,
    OP_SUBI  = 6'd20,
    OP_ADDF  = 6'd23,
    OP_MULF  = 6'd24
  } opcode_e;

  // How the immediate is formed from the instruction word.
  typedef enum logic [1:0] {
    IMM_NONE = 2'd0,
    IMM_SEXT = 2'd1,
    IMM_ZEXT = 2'd2
  } imm_kind_e;

  // Raw instruction fields.
  logic [5:0]        dec_opcode;
  logic [REG_AW-1:0] dec_rd;
  logic [REG_AW-1:0] dec_rs1;
  logic [REG_AW-1:0] dec_rs2;
  logic [15:0]       dec_imm16;
  logic [4:0]        dec_shamt;

  // Decoded control.
  imm_kind_e         dec_imm_kind;
  logic              dec_legal;
  logic              dec_reg_write;
  logic              dec_use_imm;
  logic [DATA_W-1:0] dec_imme_value;

  // Slice control.
  logic              in_xfer;
  logic              out_xfer;
  logic              load_slice;

  assign dec_opcode = in_instr[31:26];
  assign dec_rd     = in_instr[25:21];
  assign dec_rs1    = in_instr[20:16];
  assign dec_rs2    = in_instr[15:11];
  assign dec_imm16  = in_instr[15:0];
  assign dec_shamt  = in_instr[4:0];

  // Classify the opcode: legality, immediate form and whether rd is written.
  always_comb begin
    dec_legal     = 1'b1;
    dec_imm_kind  = IMM_NONE;
    dec_reg_write = 1'b1;
    case (dec_opcode)
      OP_NOP: begin
        dec_reg_write = 1'b0;
      end
      OP_STORE: begin
        // rd names the data source register, so nothing is written back.
        dec_imm_kind  = IMM_SEXT;
        dec_reg_write = 1'b0;
      end
      OP_LOAD, OP_MOVEI, OP_ADDI, OP_SUBI: begin
        dec_imm_kind = IMM_SEXT;
      end
      OP_SLI, OP_SRI: begin
        dec_imm_kind = IMM_ZEXT;
      end
      OP_ADD, OP_SUB, OP_MOVE, OP_SGE, OP_SLE, OP_SGT, OP_SLT, OP_SEQ,
      OP_SNE, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_ADDF, OP_MULF: begin
        dec_imm_kind = IMM_NONE;
      end
      default: begin
        // Unknown opcode: fields still pass through, but nothing is enabled.
        dec_legal     = 1'b0;
        dec_reg_write = 1'b0;
      end
    endcase
  end

  // Build the immediate and the operand-B select from the immediate form.
  always_comb begin
    dec_imme_value = '0;
    dec_use_imm    = 1'b0;
    case (dec_imm_kind)
      IMM_SEXT: begin
        dec_imme_value = {{(DATA_W-16){dec_imm16[15]}}, dec_imm16};
        dec_use_imm    = 1'b1;
      end
      IMM_ZEXT: begin
        dec_imme_value = {{(DATA_W-5){1'b0}}, dec_shamt};
        dec_use_imm    = 1'b1;
      end
      default: begin
        dec_imme_value = '0;
        dec_use_imm    = 1'b0;
      end
    endcase
  end

  // The slice can take a word when it is empty or being drained this cycle.
  assign in_ready   = !out_valid || out_ready;
  assign in_xfer    = in_valid && in_ready;
  assign out_xfer   = out_valid && out_ready;
  assign load_slice = in_xfer && !flush;

  // Output valid: set on an accepted word, cleared when drained or flushed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (load_slice) begin
      out_valid <= 1'b1;
    end else if (out_xfer) begin
      out_valid <= 1'b0;
    end
  end

  // Payload registers: only written when a new word is accepted, so they
  // hold steady under backpressure. After a flush they keep stale contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opcode     <= '0;
      rd         <= '0;
      rs1        <= '0;
      rs2        <= '0;
      imme_value <= '0;
      use_imm    <= 1'b0;
      reg_write  <= 1'b0;
      illegal    <= 1'b0;
    end else if (load_slice) begin
      opcode     <= dec_opcode;
      rd         <= dec_rd;
      rs1        <= dec_rs1;
      rs2        <= dec_rs2;
      imme_value <= dec_imme_value;
      use_imm    <= dec_use_imm;
      reg_write  <= dec_reg_write;
      illegal    <= !dec_legal;
    end
  end

  // Delivered-instruction counter; a flushed entry is not a delivery.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_count <= '0;
    end else if (out_xfer && !flush) begin
      instr_count <= instr_count + 1'b1;
    end
  end

  // Sticky flag: an illegal instruction has actually been handed downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_seen <= 1'b0;
    end else if (out_xfer && !flush && illegal) begin
      illegal_seen <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_decode_stage.sv
// Bench for instr_decode_stage: directed vector table, hand-written
// backpressure / flush / async-reset sequences, and random traffic compared
// cycle by cycle with a transaction-level reference model.
module tb_instr_decode_stage;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int CNT_W  = 4;  // small so the counter wraps during the run

  // ---------------- clock / reset ----------------
  logic              clk = 1'b0;
  logic              rst_n;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_instr;
  logic              out_valid;
  logic              out_ready;
  logic [5:0]        opcode;
  logic [REG_AW-1:0] rd, rs1, rs2;
  logic [DATA_W-1:0] imme_value;
  logic              use_imm, reg_write, illegal, illegal_seen;
  logic [CNT_W-1:0]  instr_count;

  always #5 clk = ~clk;

  instr_decode_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
    .imme_value(imme_value), .use_imm(use_imm), .reg_write(reg_write),
    .illegal(illegal), .illegal_seen(illegal_seen), .instr_count(instr_count)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [5:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic        use_imm, reg_write, illegal;
  } dec_t;

  // Decode straight from the ISA description using opcode sets.
  function automatic dec_t ref_decode(input logic [31:0] w);
    dec_t d;
    int op;
    bit legal, sext, zext;
    op    = int'(w[31:26]);
    legal = (op <= 20) || (op == 23) || (op == 24);
    sext  = op inside {3, 4, 16, 19, 20};
    zext  = op inside {17, 18};
    d.op  = w[31:26];
    d.rd  = w[25:21];
    d.rs1 = w[20:16];
    d.rs2 = w[15:11];
    if (sext)      d.imm = 32'($signed({16'b0, w[15:0]} << 16) >>> 16);
    else if (zext) d.imm = w[31:0] % 32;
    else           d.imm = 32'd0;
    d.use_imm   = sext || zext;
    d.reg_write = legal && (op != 0) && (op != 3);
    d.illegal   = !legal;
    return d;
  endfunction

  // Scoreboard: exp_q holds the word currently expected in the output slice.
  logic [DATA_W-1:0] exp_q[$];
  int                m_count  = 0;
  bit                m_sticky = 1'b0;

  task automatic model_reset();
    exp_q.delete();
    m_count  = 0;
    m_sticky = 1'b0;
  endtask

  task automatic check_outputs();
    dec_t e;
    chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
    chk("instr_count", 32'(instr_count), 32'(m_count));
    chk("illegal_seen", 32'(illegal_seen), 32'(m_sticky));
    if (exp_q.size() != 0) begin
      e = ref_decode(exp_q[0]);
      chk("opcode", 32'(opcode), 32'(e.op));
      chk("rd", 32'(rd), 32'(e.rd));
      chk("rs1", 32'(rs1), 32'(e.rs1));
      chk("rs2", 32'(rs2), 32'(e.rs2));
      chk("imme_value", imme_value, e.imm);
      chk("use_imm", 32'(use_imm), 32'(e.use_imm));
      chk("reg_write", 32'(reg_write), 32'(e.reg_write));
      chk("illegal", 32'(illegal), 32'(e.illegal));
    end
  endtask

  // ---------------- driver ----------------
  // Called just after a falling edge: drive, check in_ready, clock, check outputs.
  task automatic step(input bit f, input bit iv, input logic [31:0] w, input bit ordy);
    bit m_valid, hs, xfer;
    flush = f; in_valid = iv; in_instr = w; out_ready = ordy;
    m_valid = exp_q.size() != 0;
    #1;
    chk("in_ready", 32'(in_ready), 32'(!m_valid || ordy));
    @(posedge clk);
    hs   = m_valid && ordy && !f;
    xfer = iv && (!m_valid || ordy) && !f;
    if (hs) begin
      m_count = (m_count + 1) % (1 << CNT_W);
      if (ref_decode(exp_q[0]).illegal) m_sticky = 1'b1;
    end
    if (f) exp_q.delete();
    else begin
      if (hs) void'(exp_q.pop_front());
      if (xfer) exp_q.push_back(w);
    end
    @(negedge clk);
    check_outputs();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [31:0] instr;
    logic [5:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    bit          use_imm, reg_write, illegal;
  } vec_t;

  vec_t vecs[9];

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  initial begin : main
    int c0;
    logic [31:0] w;
    vecs[0] = '{32'h4C61FFFB, 6'd19, 5'd3, 5'd1, 5'd31, 32'hFFFFFFFB, 1, 1, 0}; // ADDI
    vecs[1] = '{32'h04822800, 6'd1,  5'd4, 5'd2, 5'd5,  32'h0,        0, 1, 0}; // ADD
    vecs[2] = '{32'h44000025, 6'd17, 5'd0, 5'd0, 5'd0,  32'h5,        1, 1, 0}; // SLI
    vecs[3] = '{32'h0C008000, 6'd3,  5'd0, 5'd0, 5'd16, 32'hFFFF8000, 1, 0, 0}; // STORE
    vecs[4] = '{32'h54001234, 6'd21, 5'd0, 5'd0, 5'd2,  32'h0,        0, 0, 1}; // op 21
    vecs[5] = '{32'h40007FFF, 6'd16, 5'd0, 5'd0, 5'd15, 32'h00007FFF, 1, 1, 0}; // MOVEI
    vecs[6] = '{32'h00000000, 6'd0,  5'd0, 5'd0, 5'd0,  32'h0,        0, 0, 0}; // NOP
    vecs[7] = '{32'h6063FFFF, 6'd24, 5'd3, 5'd3, 5'd31, 32'h0,        0, 1, 0}; // MULF
    vecs[8] = '{32'hFC000000, 6'd63, 5'd0, 5'd0, 5'd0,  32'h0,        0, 0, 1}; // op 63

    rst_n = 1'b0; flush = 0; in_valid = 0; in_instr = '0; out_ready = 0;
    repeat (2) @(negedge clk);
    chk("reset out_valid", 32'(out_valid), 0);
    chk("reset in_ready", 32'(in_ready), 1);
    chk("reset fields", {opcode, rd, rs1, rs2, 11'b0}, 0);
    chk("reset imme_value", imme_value, 0);
    chk("reset flags", {use_imm, reg_write, illegal, illegal_seen}, 0);
    chk("reset instr_count", 32'(instr_count), 0);
    rst_n = 1'b1;
    model_reset();

    // Table: each vector issued alone, checked against its hand-written fields.
    for (int i = 0; i < 9; i++) begin
      step(0, 1, vecs[i].instr, 1);
      chk("tbl out_valid", 32'(out_valid), 1);
      chk("tbl opcode", 32'(opcode), 32'(vecs[i].op));
      chk("tbl rd", 32'(rd), 32'(vecs[i].rd));
      chk("tbl rs1", 32'(rs1), 32'(vecs[i].rs1));
      chk("tbl rs2", 32'(rs2), 32'(vecs[i].rs2));
      chk("tbl imme_value", imme_value, vecs[i].imm);
      chk("tbl use_imm", 32'(use_imm), 32'(vecs[i].use_imm));
      chk("tbl reg_write", 32'(reg_write), 32'(vecs[i].reg_write));
      chk("tbl illegal", 32'(illegal), 32'(vecs[i].illegal));
    end
    step(0, 0, 32'h0, 1); // drain the last one (op 63, illegal)
    chk("illegal_seen sticky", 32'(illegal_seen), 1);
    chk("count after table", 32'(instr_count), 9);

    // Backpressure: hold ADDI for 3 cycles while ADD waits, then release.
    step(0, 1, vecs[0].instr, 1);
    c0 = int'(instr_count);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, vecs[1].instr, 0);
      chk("bp in_ready", 32'(in_ready), 0);
      chk("bp opcode held", 32'(opcode), 19);
      chk("bp count held", 32'(instr_count), 32'(c0));
    end
    step(0, 1, vecs[1].instr, 1);
    chk("bp count+1", 32'(instr_count), 32'((c0 + 1) % 16));
    chk("bp next loaded", 32'(opcode), 1);
    step(0, 0, 32'h0, 1); // empty the slice

    // Five back-to-back instructions deliver 5 in 6 cycles.
    c0 = int'(instr_count);
    for (int i = 0; i < 5; i++) step(0, 1, vecs[i + 1].instr, 1);
    step(0, 0, 32'h0, 1);
    chk("stream count", 32'(instr_count), 32'((c0 + 5) % 16));
    chk("stream empty", 32'(out_valid), 0);

    // Flush with a held entry and a concurrent input word.
    step(0, 1, vecs[0].instr, 0);
    c0 = int'(instr_count);
    step(1, 1, vecs[1].instr, 1);
    chk("flush out_valid", 32'(out_valid), 0);
    chk("flush count", 32'(instr_count), 32'(c0));
    step(0, 0, 32'h0, 1);
    chk("flush no revival", 32'(out_valid), 0);

    // Asynchronous reset mid-stream.
    step(0, 1, vecs[4].instr, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("async out_valid", 32'(out_valid), 0);
    chk("async in_ready", 32'(in_ready), 1);
    chk("async fields", {opcode, rd, rs1, rs2, 11'b0}, 0);
    chk("async flags", {use_imm, reg_write, illegal, illegal_seen}, 0);
    chk("async count", 32'(instr_count), 0);
    chk("async imme_value", imme_value, 0);
    model_reset();
    in_valid = 0;
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic against the model (counter wraps several times).
    for (int i = 0; i < 600; i++) begin
      w = $urandom();
      if ($urandom_range(0, 3) != 0) w[31:26] = 6'($urandom_range(0, 25));
      step($urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0, w,
           $urandom_range(0, 2) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_decode_stage.md
Name: instr_decode_stage

Overview:
- Pipelined instruction-decode stage between fetch and the operand-select/ALU stage.
- Accepts a 32-bit instruction word over a valid/ready handshake and splits it into fields.
- Produces the 6-bit opcode, register addresses, and a 32-bit extended immediate.
- Emits control flags (use_imm, reg_write, illegal) that downstream operand muxing and writeback consume.
- One output register slice with backpressure and flush.

Parameters:
- DATA_W, 32, instruction and immediate width
- REG_AW, 5, register address width
- CNT_W, 32, width of decoded-instruction counter

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  discard held/incoming instruction (branch redirect)
- in_valid  in  1  instruction word valid
- in_ready  out  1  stage can accept instruction this cycle
- in_instr  in  32  instruction word
- out_valid  out  1  decoded fields valid
- out_ready  in  1  downstream accepts decoded fields
- opcode  out  6  instr[31:26]
- rd  out  5  instr[25:21]
- rs1  out  5  instr[20:16]
- rs2  out  5  instr[15:11]
- imme_value  out  32  extended immediate
- use_imm  out  1  operand B is imme_value, not rs2 data
- reg_write  out  1  instruction writes rd
- illegal  out  1  opcode not in ISA
- illegal_seen  out  1  sticky: an illegal instruction has been emitted
- instr_count  out  CNT_W  count of completed output handshakes

Behaviour:
- Reset (async, rst_n=0): all outputs 0. This includes out_valid, fields, flags, illegal_seen, and instr_count. in_ready=1 after reset.
- Opcode map (decimal):
  - NOP=0, ADD=1, SUB=2, STORE=3, LOAD=4, MOVE=5, SGE=6, SLE=7, SGT=8, SLT=9, SEQ=10, SNE=11.
  - AND=12, OR=13, XOR=14, NOT=15, MOVEI=16, SLI=17, SRI=18, ADDI=19, SUBI=20, ADDF=23, MULF=24.
  - All other values (21, 22, 25-63) are illegal.
- Immediate:
  - ADDI, SUBI, LOAD, STORE, MOVEI: imme_value = sign-extended instr[15:0].
  - SLI, SRI: imme_value = zero-extended instr[4:0].
  - All other opcodes: imme_value = 0.
- use_imm: 1 for SLI, SRI, ADDI, SUBI, STORE, MOVEI, LOAD; 0 otherwise, including illegal.
- reg_write: 1 for every legal opcode except NOP and STORE. STORE carries its data-source register in rd. reg_write = 0 when illegal.
- illegal: 1 only for the illegal opcode set. Fields are still decoded, with use_imm=0, reg_write=0, imme_value=0.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - A transfer occurs when in_valid && in_ready. Decoded fields are registered on that edge, so latency is 1 cycle: out_valid rises the next cycle.
  - Output holds stable while out_valid && !out_ready.
  - out_valid clears after an output handshake with no new input.
- Simultaneous events: on an output handshake with a concurrent input transfer, the new instruction replaces the old one in the same cycle (full throughput, 1 instr/cycle).
- Flush:
  - Synchronous. On the next edge out_valid=0 and any same-cycle input transfer is dropped. Flush overrides in_valid.
  - instr_count does not increment for a flushed entry. Field registers may retain stale values.
- instr_count: increments by 1 on each out_valid && out_ready cycle and wraps from 2^CNT_W-1 to 0.
- illegal_seen: set on an output handshake with illegal=1; cleared only by reset.
- Reset mid-operation: a held instruction is lost and out_valid=0 immediately (async).

Test Plan:
- ADDI r3,r1,-5: in_instr=0x4C61FFFB, out_ready=1 -> next cycle out_valid=1, opcode=19, rd=3, rs1=1, imme_value=0xFFFFFFFB, use_imm=1, reg_write=1, illegal=0.
- ADD r4,r2,r5: in_instr=0x04822800 -> opcode=1, rd=4, rs1=2, rs2=5, use_imm=0, imme_value=0, reg_write=1.
- SLI with instr[15:0]=0x0025 (opcode 17) -> imme_value=0x00000005, use_imm=1. STORE with imm 0x8000 -> imme_value=0xFFFF8000, reg_write=0.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs stable, instr_count unchanged. Then out_ready=1 -> count+1 and the next instruction loads the same cycle. A 5-instruction back-to-back stream gives instr_count=5 in 6 cycles.
- Illegal opcode 21 -> illegal=1, reg_write=0, use_imm=0. After its handshake illegal_seen=1 and stays 1 through later legal instructions.
- Flush with out_valid=1 and in_valid=1 -> next cycle out_valid=0 and instr_count unchanged. Also assert rst_n=0 mid-stream -> all outputs 0 without waiting for a clock edge.
